song_sequencer: RTL and testbench
=================================

# song_sequencer

Playback controller for one voice of the song note ROMs. It walks the ROM address across a configured index range and holds each entry's note for `duration × BEAT_DIV` clock cycles. Entries are 16 bits wide: `{duration[15:8], note[7:0]}`. Outputs are a registered note number, a gate and an onset pulse for the downstream tone generator. One instance is placed per voice, so three voices run in parallel, and all instances share the same `start`/`stop` strobes.

## Interface
Parameters:
- `BEAT_DIV`, default 16: clock cycles per duration unit (one beat). Must be ≥2.
- `START_IDX`, default 4: first ROM index played.
- `END_IDX`, default 26: last ROM index played. Must be ≥ `START_IDX`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset. Synchronous, active-high.
- `start` in 1: one-cycle strobe. Begins playback from `START_IDX`. Ignored while `busy`.
- `stop` in 1: one-cycle strobe. Aborts playback. Wins over a simultaneous `start`.
- `pause` in 1: level. While high, freezes the prescaler, the remaining-beat count and the state. Forces `gate` low.
- `loop_en` in 1: level, sampled at end of song. When high, playback restarts at `START_IDX` instead of finishing.
- `rom_addr` out 10: registered index driven to the ROM `count` input.
- `rom_data` in 16: asynchronous ROM read data for `rom_addr`.
- `note` out 8: current note number. 0 means rest.
- `gate` out 1: high while a non-rest note sounds.
- `note_on` out 1: one-cycle pulse when a new entry starts playing, including rests.
- `beat_tick` out 1: one-cycle pulse at every beat boundary while playing.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the song ends without looping.

## Operation
- States are IDLE, FETCH and PLAY.
- Reset behaviour:
  - State goes to IDLE.
  - `rom_addr` is set to `START_IDX`.
  - `note`, `gate`, `note_on`, `beat_tick`, `busy` and `done` are all 0.
  - The prescaler and the remaining-beat counter (8 bits) are cleared.
- IDLE:
  - `start` moves to FETCH with `rom_addr` = `START_IDX`.
- FETCH:
  - The block samples `rom_data`.
  - If duration is 0, the entry is skipped:
    - If `rom_addr` == `END_IDX`, the end-of-song rule applies.
    - Otherwise `rom_addr` increments and the state stays in FETCH.
  - If duration is non-zero:
    - `note` is loaded with `rom_data[7:0]`.
    - `remaining` is loaded with the duration.
    - The prescaler is cleared.
    - `note_on` pulses.
    - The state moves to PLAY.
- PLAY:
  - The prescaler counts from 0 to `BEAT_DIV`-1.
  - When it reaches `BEAT_DIV`-1, `beat_tick` pulses and `remaining` decrements.
  - On the tick where `remaining` == 1:
    - If `rom_addr` == `END_IDX`, the end-of-song rule applies.
    - Otherwise `rom_addr` increments and the state moves to FETCH.
- End-of-song rule:
  - If `loop_en` = 1: `rom_addr` is set to `START_IDX` and the state moves to FETCH. There is no `done` pulse.
  - If `loop_en` = 0: `done` pulses, the state moves to IDLE, and `note` and `gate` clear to 0.
- `gate` = (state == PLAY) && `note` != 0 && !`pause`.
  - During FETCH, `note` holds its previous value and `gate` is 0.
  - This gives one cycle of articulation between consecutive notes.
- `stop` in any state:
  - The state moves to IDLE next cycle.
  - `note` and `gate` go to 0, and `rom_addr` goes to `START_IDX`.
  - There is no `done` pulse.
- `pause` applies in FETCH as well: the state holds and `rom_addr` does not advance.
- `stop` overrides `pause`.
- Arithmetic:
  - `rom_addr` is 10 bits and does not wrap past `END_IDX`, because the end-of-song rule always fires first.
  - `remaining` is never decremented below 1.

## Timing
- `start` high at cycle T (in IDLE):
  - T+1: FETCH, `busy` = 1, `rom_addr` = `START_IDX`.
  - T+2: PLAY, with `note`, `gate` and `note_on` valid.
- An entry of duration d occupies 1 FETCH cycle plus d×`BEAT_DIV` PLAY cycles.
- A zero-duration entry costs 1 FETCH cycle and produces no output pulse.
- `note_on` and `note` update in the same cycle.
- `beat_tick` is asserted in the last PLAY cycle of each beat.
- `done` is asserted in the first IDLE cycle after the final beat. `busy` is 0 in that same cycle.
- The ROM read is combinational; `rom_data` is valid in the same cycle as `rom_addr`.

## Test plan
- **Basic playback.** Setup: `BEAT_DIV`=4, `START_IDX`=4, `END_IDX`=5, ROM[4]={1,55}, ROM[5]={1,56}. Stimulus: `start`.
  - `note_on` pulses at T+2 and T+7.
  - `note` is 55, then 56.
  - `gate` is low at T+6.
  - `done` pulses at T+11 and `busy` falls at T+11.
- **Long note.** ROM[15]={3,58}, `BEAT_DIV`=4.
  - `note` holds 58 for 12 cycles.
  - Three `beat_tick` pulses occur, 4 cycles apart.
- **Skips and rests.** ROM[9]={0,x}, ROM[10]={2,0}.
  - Entry 9 costs 1 cycle with no `note_on`.
  - Entry 10 pulses `note_on` with `note`=0 and `gate` stays low for 8 cycles.
- **Loop.** `loop_en`=1, 2-entry song.
  - After the last beat, `rom_addr` returns to 4 and the second `note_on` for 55 appears.
  - No `done` pulse.
  - Clearing `loop_en` ends the song on the next pass.
- **Pause.** `pause` high for 10 cycles mid-note.
  - `gate` is 0 and no `beat_tick` occurs.
  - After `pause` falls, the note resumes and is extended by exactly 10 cycles.
- **Stop and reset.**
  - `stop` and `start` together mid-note: IDLE next cycle, `note`=0, no `done`.
  - `rst` mid-PLAY: all outputs 0 next cycle and `rom_addr`=`START_IDX`.
  - `start` while `busy` is ignored.

Source files
------------

// File: rtl/song_sequencer.sv
// song_sequencer: single-voice note ROM playback controller with beat prescaler
module song_sequencer #(
   parameter int BEAT_DIV  = 16,
   parameter int START_IDX = 4,
   parameter int END_IDX   = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        pause,
   input  logic        loop_en,
   output logic [9:0]  rom_addr,
   input  logic [15:0] rom_data,
   output logic [7:0]  note,
   output logic        gate,
   output logic        note_on,
   output logic        beat_tick,
   output logic        busy,
   output logic        done
);
   localparam int PW = $clog2(BEAT_DIV);
   localparam logic [PW-1:0] P_LAST = PW'(BEAT_DIV - 1);
   localparam logic [9:0] S_IDX = 10'(START_IDX);
   localparam logic [9:0] E_IDX = 10'(END_IDX);
   typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
   state_t state;
   logic [PW-1:0] presc;
   logic [7:0] remaining;
   logic last, tick;
   assign last      = rom_addr == E_IDX;
   assign tick      = state == PLAY && !pause && presc == P_LAST;
   assign beat_tick = tick;
   assign gate      = state == PLAY && note != 8'd0 && !pause;
   assign busy      = state != IDLE;
   // playback FSM: fetch entries, count beats, advance or end the song
   always_ff @(posedge clk) begin
      if (rst || stop) begin
         state     <= IDLE;
         rom_addr  <= S_IDX;
         note      <= 8'd0;
         note_on   <= 1'b0;
         done      <= 1'b0;
         presc     <= '0;
         remaining <= 8'd0;
      end else begin
         note_on <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state    <= FETCH;
               rom_addr <= S_IDX;
            end
            FETCH: if (!pause) begin
               if (rom_data[15:8] == 8'd0) begin
                  if (!last) rom_addr <= rom_addr + 10'd1;
                  else if (loop_en) rom_addr <= S_IDX;
                  else begin
                     done  <= 1'b1;
                     state <= IDLE;
                     note  <= 8'd0;
                  end
               end else begin
                  note      <= rom_data[7:0];
                  remaining <= rom_data[15:8];
                  presc     <= '0;
                  note_on   <= 1'b1;
                  state     <= PLAY;
               end
            end
            PLAY: if (!pause) begin
               presc <= tick ? '0 : presc + 1'b1;
               if (tick) begin
                  if (remaining > 8'd1) remaining <= remaining - 8'd1;
                  else if (!last) begin
                     rom_addr <= rom_addr + 10'd1;
                     state    <= FETCH;
                  end else if (loop_en) begin
                     rom_addr <= S_IDX;
                     state    <= FETCH;
                  end else begin
                     done  <= 1'b1;
                     state <= IDLE;
                     note  <= 8'd0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer: directed checks of playback, rests, loop, pause, stop and reset
module tb_song_sequencer;
   logic        clk = 1'b0;
   logic        rst, start, stop, pause, loop_en;
   logic [9:0]  rom_addr;
   logic [15:0] rom_data;
   logic [7:0]  note;
   logic        gate, note_on, beat_tick, busy, done;
   logic [15:0] rom [0:1023];
   int tests = 0;
   int failed = 0;

   song_sequencer #(.BEAT_DIV(4), .START_IDX(4), .END_IDX(5)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
      .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
      .note(note), .gate(gate), .note_on(note_on), .beat_tick(beat_tick),
      .busy(busy), .done(done)
   );

   assign rom_data = rom[rom_addr];

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 16'h0000;
      rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
      cyc(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_addr", 32'(rom_addr), 4);
      chk("rst_note", 32'(note), 0);
      chk("rst_gate", 32'(gate), 0);
      chk("rst_note_on", 32'(note_on), 0);
      chk("rst_tick", 32'(beat_tick), 0);
      chk("rst_done", 32'(done), 0);
      rst = 1'b0;
      cyc(1);

      // basic playback
      rom[4] = 16'h0137; rom[5] = 16'h0138;
      start = 1'b1; cyc(1); start = 1'b0;
      chk("b_busy_t1", 32'(busy), 1);
      chk("b_addr_t1", 32'(rom_addr), 4);
      chk("b_gate_t1", 32'(gate), 0);
      cyc(1);
      chk("b_non_t2", 32'(note_on), 1);
      chk("b_note_t2", 32'(note), 55);
      chk("b_gate_t2", 32'(gate), 1);
      cyc(3);
      chk("b_tick_t5", 32'(beat_tick), 1);
      cyc(1);
      chk("b_gate_t6", 32'(gate), 0);
      chk("b_addr_t6", 32'(rom_addr), 5);
      chk("b_note_t6", 32'(note), 55);
      cyc(1);
      chk("b_non_t7", 32'(note_on), 1);
      chk("b_note_t7", 32'(note), 56);
      cyc(3);
      chk("b_tick_t10", 32'(beat_tick), 1);
      chk("b_done_t10", 32'(done), 0);
      cyc(1);
      chk("b_done_t11", 32'(done), 1);
      chk("b_busy_t11", 32'(busy), 0);
      chk("b_note_t11", 32'(note), 0);
      cyc(1);
      chk("b_done_t12", 32'(done), 0);
      cyc(2);

      // long note followed by a zero-duration last entry
      rom[4] = 16'h033A; rom[5] = 16'h0000;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      chk("l_non", 32'(note_on), 1);
      for (int i = 0; i < 12; i++) begin
         if (i > 0) cyc(1);
         chk("l_note", 32'(note), 58);
         chk("l_tick", 32'(beat_tick), 32'(i % 4 == 3));
      end
      cyc(1);
      chk("l_gate_fetch", 32'(gate), 0);
      chk("l_addr_fetch", 32'(rom_addr), 5);
      cyc(1);
      chk("l_done", 32'(done), 1);
      chk("l_busy", 32'(busy), 0);
      chk("l_non_skip", 32'(note_on), 0);
      cyc(2);

      // skipped entry then a rest
      rom[4] = 16'h0099; rom[5] = 16'h0200;
      start = 1'b1; cyc(1); start = 1'b0;
      chk("s_addr_t1", 32'(rom_addr), 4);
      cyc(1);
      chk("s_addr_t2", 32'(rom_addr), 5);
      chk("s_non_t2", 32'(note_on), 0);
      chk("s_busy_t2", 32'(busy), 1);
      cyc(1);
      chk("s_non_t3", 32'(note_on), 1);
      chk("s_note_t3", 32'(note), 0);
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cyc(1);
         chk("s_gate_rest", 32'(gate), 0);
         chk("s_busy_rest", 32'(busy), 1);
      end
      cyc(1);
      chk("s_done", 32'(done), 1);
      cyc(2);

      // loop once, then finish on the next pass
      rom[4] = 16'h0137; rom[5] = 16'h0138;
      loop_en = 1'b1;
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(6);
      chk("p_non_t7", 32'(note_on), 1);
      chk("p_note_t7", 32'(note), 56);
      cyc(4);
      chk("p_addr_t11", 32'(rom_addr), 4);
      chk("p_done_t11", 32'(done), 0);
      chk("p_busy_t11", 32'(busy), 1);
      cyc(1);
      chk("p_non_t12", 32'(note_on), 1);
      chk("p_note_t12", 32'(note), 55);
      loop_en = 1'b0;
      cyc(4);
      chk("p_addr_t16", 32'(rom_addr), 5);
      cyc(4);
      chk("p_done_t20", 32'(done), 0);
      cyc(1);
      chk("p_done_t21", 32'(done), 1);
      cyc(2);

      // pause mid-note for 10 cycles
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(1);
      chk("z_non_t2", 32'(note_on), 1);
      cyc(1);
      pause = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         chk("z_gate_paused", 32'(gate), 0);
         chk("z_tick_paused", 32'(beat_tick), 0);
      end
      chk("z_note_paused", 32'(note), 55);
      pause = 1'b0;
      cyc(1);
      chk("z_gate_t14", 32'(gate), 1);
      chk("z_tick_t14", 32'(beat_tick), 0);
      cyc(1);
      chk("z_tick_t15", 32'(beat_tick), 1);
      cyc(1);
      chk("z_addr_t16", 32'(rom_addr), 5);
      chk("z_gate_t16", 32'(gate), 0);
      cyc(5);
      chk("z_done_t21", 32'(done), 1);
      cyc(2);

      // stop together with start mid-note
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      stop = 1'b1; start = 1'b1;
      cyc(1);
      stop = 1'b0; start = 1'b0;
      chk("x_busy", 32'(busy), 0);
      chk("x_note", 32'(note), 0);
      chk("x_gate", 32'(gate), 0);
      chk("x_done", 32'(done), 0);
      chk("x_addr", 32'(rom_addr), 4);
      cyc(1);
      chk("x_busy_after", 32'(busy), 0);
      chk("x_done_after", 32'(done), 0);
      cyc(2);

      // start while busy is ignored, then reset mid-PLAY
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("i_tick_t5", 32'(beat_tick), 1);
      chk("i_non_t5", 32'(note_on), 0);
      chk("i_note_t5", 32'(note), 55);
      cyc(1);
      chk("i_addr_t6", 32'(rom_addr), 5);
      cyc(1);
      chk("i_note_t7", 32'(note), 56);
      cyc(1);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("r_busy", 32'(busy), 0);
      chk("r_note", 32'(note), 0);
      chk("r_gate", 32'(gate), 0);
      chk("r_note_on", 32'(note_on), 0);
      chk("r_tick", 32'(beat_tick), 0);
      chk("r_done", 32'(done), 0);
      chk("r_addr", 32'(rom_addr), 4);
      cyc(2);
      chk("r_busy_after", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
